// File: rtl/i2c_mst_single_byte.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP, bus-free time.
// Handshake: i_start is taken only in IDLE; o_done pulses one cycle when the bus is free again.
module i2c_mst_single_byte #(
  parameter int CLKS_PER_QTR = 4,
  parameter int WIDTH_QTR    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic [7:0] o_rdata,
  output logic [2:0] o_dbg_state
);

  localparam logic [WIDTH_QTR-1:0] QMAX = WIDTH_QTR'(CLKS_PER_QTR - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_BUF, S_DONE} state_t;

  state_t               state, state_n;
  logic [WIDTH_QTR-1:0] qcnt, qcnt_n;
  logic [1:0]           qidx, qidx_n;
  logic [4:0]           slot, slot_n;
  logic                 rw_q;
  logic [6:0]           addr_q;
  logic [7:0]           wdata_q;
  logic [7:0]           shreg;
  logic                 stretch, qend, smp;
  logic                 bit_val, scl_n, sda_n;

  assign o_dbg_state = state;

  // A low SCL while we release it is a slave stretch: the quarter restarts from 0.
  always_comb begin
    stretch = ((state == S_BITS && qidx == 2'd2) || (state == S_STOP && qidx == 2'd1)) && !i_scl;
    qend    = (qcnt == QMAX) && !stretch;
    smp     = (state == S_BITS) && (qidx == 2'd3) && (qcnt == '0);
  end

  always_comb begin
    state_n = state;
    qidx_n  = qidx;
    slot_n  = slot;
    if (state == S_IDLE || state == S_DONE || stretch || qend) qcnt_n = '0;
    else qcnt_n = qcnt + 1'b1;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_n = S_START;
          qidx_n  = 2'd0;
        end
      end
      S_START: begin
        if (qend) begin
          if (qidx == 2'd1) begin
            state_n = S_BITS;
            qidx_n  = 2'd0;
            slot_n  = 5'd0;
          end else qidx_n = qidx + 2'd1;
        end
      end
      S_BITS: begin
        if (qend) begin
          qidx_n = qidx + 2'd1;
          if (qidx == 2'd3) begin
            qidx_n = 2'd0;
            if (slot == 5'd17 || (slot == 5'd8 && o_ack_err)) state_n = S_STOP;
            else slot_n = slot + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (qend) begin
          if (qidx == 2'd2) begin
            state_n = S_BUF;
            qidx_n  = 2'd0;
          end else qidx_n = qidx + 2'd1;
        end
      end
      S_BUF: begin
        if (qend) begin
          if (qidx == 2'd3) state_n = S_DONE;
          else qidx_n = qidx + 2'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line levels follow the next state so SCL/SDA line up with the FSM quarter boundaries.
  always_comb begin
    bit_val = 1'b1;
    if (slot_n < 5'd7) bit_val = addr_q[3'(5'd6 - slot_n)];
    else if (slot_n == 5'd7) bit_val = rw_q;
    else if (slot_n >= 5'd9 && slot_n <= 5'd16 && !rw_q) bit_val = wdata_q[3'(5'd16 - slot_n)];
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      S_START: sda_n = (qidx_n == 2'd0);
      S_BITS: begin
        scl_n = qidx_n[1];
        sda_n = bit_val;
      end
      S_STOP: begin
        scl_n = (qidx_n != 2'd0);
        sda_n = (qidx_n == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      qidx      <= 2'd0;
      slot      <= 5'd0;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 8'd0;
      shreg     <= 8'd0;
      o_ack_err <= 1'b0;
      o_rdata   <= 8'd0;
      o_scl     <= 1'b1;
      o_sda     <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state  <= state_n;
      qcnt   <= qcnt_n;
      qidx   <= qidx_n;
      slot   <= slot_n;
      o_scl  <= scl_n;
      o_sda  <= sda_n;
      o_busy <= (state != S_IDLE) && (state != S_DONE);
      o_done <= (state == S_DONE);
      if (state == S_IDLE && i_start) begin
        rw_q      <= i_rw;
        addr_q    <= i_addr;
        wdata_q   <= i_wdata;
        o_ack_err <= 1'b0;
      end
      if (smp) begin
        if ((slot == 5'd8 || (slot == 5'd17 && !rw_q)) && i_sda) o_ack_err <= 1'b1;
        if (slot >= 5'd9 && slot <= 5'd16) shreg <= {shreg[6:0], i_sda};
      end
      if (state == S_BITS && state_n == S_STOP && slot == 5'd17 && rw_q) o_rdata <= shreg;
    end
  end

endmodule

// File: tb/tb_i2c_mst_single_byte.sv
// Bench for i2c_mst_single_byte: wired-AND bus, behavioural single-byte slave with bus monitor.
module tb_i2c_mst_single_byte;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start, i_rw;
  logic [6:0] i_addr;
  logic [7:0] i_wdata;
  logic       i_scl, i_sda;
  logic       o_scl, o_sda, o_busy, o_done, o_ack_err;
  logic [7:0] o_rdata;
  logic [2:0] o_dbg_state;

  logic sl_scl = 1'b1, sl_sda = 1'b1;
  assign i_scl = o_scl & sl_scl;
  assign i_sda = o_sda & sl_sda;

  i2c_mst_single_byte #(.CLKS_PER_QTR(4), .WIDTH_QTR(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rw(i_rw), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_scl(i_scl), .i_sda(i_sda), .o_scl(o_scl), .o_sda(o_sda),
    .o_busy(o_busy), .o_done(o_done), .o_ack_err(o_ack_err), .o_rdata(o_rdata),
    .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave / monitor state
  logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_oscl = 1'b1;
  logic        bs, bd;
  logic        in_frame = 1'b0, skip_fall = 1'b0;
  int          mon_n = 0;
  logic [17:0] mon_sr = '0;
  logic [6:0]  sl_addr = 7'h2A;
  logic [7:0]  sl_rdata;
  logic        sl_dack;
  logic        sl_acked = 1'b0, sl_rw = 1'b0;
  logic [7:0]  sl_cap = 8'h00;
  logic        str_arm;
  logic        str_fired = 1'b0, str_on = 1'b0;
  int          str_left = 0;
  int          str_cnt = 0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      in_frame = 1'b0; mon_n = 0; sl_sda = 1'b1; sl_scl = 1'b1; str_on = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_oscl = 1'b1;
    end else begin
      if (str_on) begin
        if (str_left > 0) str_left--;
        else begin sl_scl = 1'b1; str_on = 1'b0; end
      end else if (str_arm && !str_fired && in_frame && o_scl && !prev_oscl && mon_n == 3) begin
        sl_scl = 1'b0; str_left = 19; str_on = 1'b1; str_fired = 1'b1;
      end
      if (!sl_scl) str_cnt++;
      bs = o_scl & sl_scl;
      bd = o_sda & sl_sda;
      if (prev_scl && bs && prev_sda && !bd) begin
        in_frame = 1'b1; skip_fall = 1'b1; mon_n = 0; mon_sr = '0; sl_acked = 1'b0; str_fired = 1'b0;
      end else if (prev_scl && bs && !prev_sda && bd) begin
        in_frame = 1'b0; sl_sda = 1'b1;
      end else if (in_frame && prev_scl && !bs) begin
        if (skip_fall) skip_fall = 1'b0;
        else begin
          mon_sr = {mon_sr[16:0], prev_sda};
          mon_n++;
          if (mon_n == 17) sl_cap = mon_sr[7:0];
          sl_sda = 1'b1;
          if (mon_n == 8) begin
            sl_rw = mon_sr[0];
            sl_acked = (mon_sr[7:1] == sl_addr);
            sl_sda = !sl_acked;
          end else if (sl_acked && sl_rw && mon_n >= 9 && mon_n <= 16) sl_sda = sl_rdata[16 - mon_n];
          else if (sl_acked && !sl_rw && mon_n == 17) sl_sda = !sl_dack;
        end
      end
      prev_scl = bs; prev_sda = bd; prev_oscl = o_scl;
    end
  end

  task automatic run_txn(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         input int glitch_at, output int cyc, output logic b0, output logic b1);
    @(negedge i_clk);
    i_rw = rw; i_addr = a; i_wdata = d; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    b0 = o_busy; b1 = 1'b0; cyc = 0;
    while (cyc < 2000) begin
      @(posedge i_clk); #1;
      cyc++;
      if (cyc == 1) b1 = o_busy;
      if (glitch_at != 0 && cyc == glitch_at) begin
        i_start = 1'b1; i_rw = 1'b1; i_addr = 7'h11; i_wdata = 8'h00;
      end
      if (glitch_at != 0 && cyc == glitch_at + 1) i_start = 1'b0;
      if (o_done) break;
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  sl_rd;
    logic        dack;
    logic [17:0] bits;
    int          nbits;
    logic        err;
    logic [7:0]  rdata;
    int          cycles;
    logic        cap_chk;
  } vec_t;

  vec_t vt[8];
  int   cyc, s0, wd;
  logic b0, b1;

  initial begin
    vt[0] = '{1'b0, 7'h2A, 8'h5A, 8'h00, 1'b1, 18'h150B4, 18, 1'b0, 8'h00, 325, 1'b1};
    vt[1] = '{1'b1, 7'h2A, 8'h00, 8'hC3, 1'b1, 18'h15587, 18, 1'b0, 8'hC3, 325, 1'b0};
    vt[2] = '{1'b0, 7'h11, 8'h5A, 8'h00, 1'b1, 18'h00045,  9, 1'b1, 8'hC3, 181, 1'b0};
    vt[3] = '{1'b0, 7'h2A, 8'hA5, 8'h00, 1'b0, 18'h1514B, 18, 1'b1, 8'hC3, 325, 1'b1};
    vt[4] = '{1'b1, 7'h11, 8'h00, 8'hC3, 1'b1, 18'h00047,  9, 1'b1, 8'hC3, 181, 1'b0};
    vt[5] = '{1'b1, 7'h2A, 8'h00, 8'h00, 1'b1, 18'h15401, 18, 1'b0, 8'h00, 325, 1'b0};
    vt[6] = '{1'b0, 7'h2A, 8'hFF, 8'h00, 1'b1, 18'h151FE, 18, 1'b0, 8'h00, 325, 1'b1};
    vt[7] = '{1'b1, 7'h2A, 8'h00, 8'h81, 1'b1, 18'h15503, 18, 1'b0, 8'h81, 325, 1'b0};

    i_rst = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_addr = '0; i_wdata = '0;
    str_arm = 1'b0; sl_rdata = 8'h00; sl_dack = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_scl", o_scl, 1); chk("rst_sda", o_sda, 1); chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0); chk("rst_ack_err", o_ack_err, 0); chk("rst_rdata", o_rdata, 0);

    for (int i = 0; i < 8; i++) begin
      sl_rdata = vt[i].sl_rd; sl_dack = vt[i].dack;
      run_txn(vt[i].rw, vt[i].addr, vt[i].wdata, 0, cyc, b0, b1);
      chk($sformatf("v%0d_done", i), o_done, 1);
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].cycles);
      chk($sformatf("v%0d_bits", i), mon_sr, vt[i].bits);
      chk($sformatf("v%0d_nbits", i), mon_n, vt[i].nbits);
      chk($sformatf("v%0d_ack_err", i), o_ack_err, vt[i].err);
      chk($sformatf("v%0d_rdata", i), o_rdata, vt[i].rdata);
      if (vt[i].cap_chk) chk($sformatf("v%0d_slave_cap", i), sl_cap, vt[i].wdata);
      if (i == 0) begin
        chk("busy_at_accept", b0, 0);
        chk("busy_next", b1, 1);
        chk("busy_at_done", o_busy, 0);
      end
    end

    // Clock stretch of 20 cycles in q2 of slot 3
    sl_dack = 1'b1; str_arm = 1'b1; s0 = str_cnt;
    run_txn(1'b0, 7'h2A, 8'h5A, 0, cyc, b0, b1);
    str_arm = 1'b0;
    chk("str_stretch_len", str_cnt - s0, 20);
    chk("str_cycles", cyc, 345);
    chk("str_bits", mon_sr, 18'h150B4);
    chk("str_slave_cap", sl_cap, 8'h5A);
    chk("str_ack_err", o_ack_err, 0);

    // i_start pulsed mid-transaction with different fields
    run_txn(1'b0, 7'h2A, 8'h5A, 50, cyc, b0, b1);
    chk("ign_cycles", cyc, 325);
    chk("ign_bits", mon_sr, 18'h150B4);
    chk("ign_slave_cap", sl_cap, 8'h5A);
    chk("ign_rdata", o_rdata, 8'h81);
    @(posedge i_clk); #1;
    chk("ign_idle_after", o_busy, 0);

    // Reset during slot 10 of a write
    @(negedge i_clk);
    i_rw = 1'b0; i_addr = 7'h2A; i_wdata = 8'h5A; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wd = 0;
    while (!(mon_n == 10 && !o_scl) && wd < 1000) begin
      @(posedge i_clk); #1; wd++;
    end
    chk("mid_reached_slot10", (mon_n == 10) ? 1 : 0, 1);
    @(posedge i_clk); #1 i_rst = 1'b1;
    #1;
    chk("mid_rst_scl", o_scl, 1); chk("mid_rst_sda", o_sda, 1); chk("mid_rst_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    run_txn(1'b0, 7'h2A, 8'h5A, 0, cyc, b0, b1);
    chk("post_done", o_done, 1);
    chk("post_cycles", cyc, 325);
    chk("post_bits", mon_sr, 18'h150B4);
    chk("post_ack_err", o_ack_err, 0);
    chk("post_rdata", o_rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_mst_single_byte.md
# i2c_mst_single_byte

Single-byte I2C master: on request, it runs one complete START / address+R/W / ACK / data byte / ACK-or-NACK / STOP transaction on a two-wire bus and reports completion and acknowledge status. It is the initiator companion to the team's single-byte I2C slave and is used on-chip to exercise and drive that slave. It also serves as a minimal register poke/peek master. It supports slave clock stretching; it does not support multi-master arbitration, repeated START or multi-byte bursts.

## Interface
- CLKS_PER_QTR, 4, i_clk cycles per quarter SCL period; SCL period = 4*CLKS_PER_QTR; legal range ≥ 2.
- WIDTH_QTR, 8, width of the quarter-period counter; must hold CLKS_PER_QTR-1.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  transaction request; sampled only while o_busy=0.
- i_rw  in  1  0=write, 1=read; latched with i_start.
- i_addr  in  7  slave address; latched with i_start.
- i_wdata  in  8  write byte; latched with i_start.
- i_scl  in  1  bus SCL level, already synchronous to i_clk.
- i_sda  in  1  bus SDA level, already synchronous to i_clk.
- o_scl  out  1  SCL drive; 1 = release (open-drain high), 0 = pull low.
- o_sda  out  1  SDA drive; 1 = release, 0 = pull low.
- o_busy  out  1  high from the cycle after an accepted i_start until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_ack_err  out  1  status of the last transaction; 1 = address NACK, or write-data NACK.
- o_rdata  out  8  last successfully read byte.

## Operation
- Reset values: o_scl=1, o_sda=1, o_busy=0, o_done=0, o_ack_err=0, o_rdata=0; FSM in IDLE. Reset mid-transaction releases both lines immediately with no STOP; the bus recovers via the slave's idle timeout.
- The quarter counter counts 0..CLKS_PER_QTR-1; a "quarter" ends when it wraps. The FSM advances only at quarter ends.
- IDLE: lines released. If i_start=1, latch i_rw, i_addr and i_wdata; clear o_ack_err; go to START. i_start while busy is ignored.
- START (2 quarters): Q0 SCL=1, SDA=1; Q1 SCL=1, SDA=0. Then go to BITS with bit index 0.
- BITS: 18 bit slots, index 0..17, each 4 quarters:
  - q0: SCL=0; SDA updated on the first cycle of q0.
  - q1: SCL=0.
  - q2: SCL released. The quarter counter is held at 0 while i_scl=0 (clock stretch).
  - q3: SCL=1. i_sda is sampled on the first cycle of q3.
- Slot contents:
  - 0-6: address MSB first.
  - 7: R/W.
  - 8: SDA released; sample ACK.
  - 9-16: write = wdata MSB first; read = released, sampled bits shifted in MSB first.
  - 17: write = released, sample ACK; read = master drives 1 (NACK).
- Address NACK at slot 8 sets o_ack_err and jumps to STOP after slot 8, skipping slots 9-17.
- Write-data NACK at slot 17 sets o_ack_err.
- A read that completes slot 17 loads the shift register into o_rdata in the STOP entry cycle. o_rdata is otherwise held.
- STOP (3 quarters): Q0 SCL=0, SDA=0; Q1 SCL released, SDA=0, stretch hold as in q2; Q2 SCL=1, SDA=1.
- BUF (4 quarters): lines released (bus free time). Then one cycle in DONE: o_done=1, o_busy=0; return to IDLE. A new i_start is accepted the cycle after o_done.

## Timing
- With Q=CLKS_PER_QTR and no stretching, an i_start accepted at edge k gives:
  - o_busy=1 from k+1.
  - o_done=1 and o_busy=0 at edge k+1+81Q for a full transaction: 2Q START + 72Q bits + 3Q STOP + 4Q BUF.
  - o_done at edge k+1+45Q for an address NACK.
- Each cycle of i_scl=0 during q2/STOP Q1 adds exactly one cycle of latency.
- All outputs are registered. o_sda changes only while o_scl=0, except the START/STOP edges.
- With Q=4, SCL has a period of 16 i_clk cycles, with 8 low and 8 high.

## Test plan
- Write 0x5A to address 0x2A with a single-byte slave model: bus shows 0x54, ACK, 0x5A, ACK. o_ack_err=0. o_done comes 325 cycles after i_start (Q=4). The slave captures 0x5A.
- Read from address 0x2A with the slave returning 0xC3: bus shows 0x55, ACK, then the slave drives 0xC3 and the master drives NACK. o_rdata=0xC3 and o_ack_err=0.
- Write to address 0x11 with no responding slave: slot 8 is sampled 1, o_ack_err=1, STOP follows immediately, o_done comes 181 cycles after i_start, and o_rdata is unchanged.
- Slave holds i_scl low for 20 cycles in q2 of slot 3: bits are unaltered and o_done is delayed by exactly 20 cycles.
- Assert i_rst during slot 10 of a write: o_scl=o_sda=1 and o_busy=0 in the same cycle. The next i_start after release completes normally.
- Pulse i_start while o_busy=1: ignored. The latched address and data of the running transaction are unchanged.
